// File: rtl/fp_add_pkg.sv
// Shared types and field constants for the single-precision adder controller.
package fp_add_pkg;

   typedef enum logic [2:0] {
      StGetA,
      StGetB,
      StExec,
      StWrite,
      StDone
   } state_e;

   localparam int unsigned EXP_MSB      = 30;
   localparam int unsigned EXP_LSB      = 23;
   localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;

   localparam int unsigned LAT_CNT_W = 4;

   // Exponent all ones marks Inf or NaN.
   function automatic logic is_special(input logic [31:0] word);
      return word[EXP_MSB:EXP_LSB] == EXP_ALL_ONES;
   endfunction

endpackage

// File: rtl/fp_add_lat_cnt.sv
// Loadable down-counter timing the adder pipeline; saturates at zero.
module fp_add_lat_cnt
   import fp_add_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [LAT_CNT_W-1:0] load_val,
   input  logic                 en,
   output logic                 zero
);

   logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/fp_add_ctrl.sv
// Sequencing controller for the FP adder: operand capture, pipeline stepping, result hand-off.
// Define FP_ADD_CTRL_SPECIAL_EN to bypass the pipeline when either operand is Inf/NaN.
module fp_add_ctrl
   import fp_add_pkg::*;
#(
   parameter int unsigned ADD_LATENCY = 3,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   output logic             in_ready,
   output logic             ld_a,
   output logic             ld_b,
   output logic             stage_en,
   output logic             ld_res,
   output logic             sel_special,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt
);

   localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(ADD_LATENCY - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
   logic             cnt_load;
   logic             cnt_en;
   logic             cnt_zero;
   logic             special_hit;

   fp_add_lat_cnt u_lat_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (LAT_LOAD),
      .en       (cnt_en),
      .zero     (cnt_zero)
   );

   // Outputs are forced low while reset is held, including the Mealy in_ready.
   always_comb begin
      state_d    = state_q;
      done_cnt_d = done_cnt_q;
      in_ready   = 1'b0;
      ld_a       = 1'b0;
      ld_b       = 1'b0;
      stage_en   = 1'b0;
      ld_res     = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      cnt_load   = 1'b0;
      cnt_en     = 1'b0;
      if (reset) begin
         busy = (state_q != StGetA);
         unique case (state_q)
            StGetA: begin
               in_ready = 1'b1;
               if (in_valid) begin
                  ld_a    = 1'b1;
                  state_d = StGetB;
               end
            end
            StGetB: begin
               in_ready = 1'b1;
               if (in_valid) begin
                  ld_b     = 1'b1;
                  cnt_load = 1'b1;
                  state_d  = special_hit ? StWrite : StExec;
               end
            end
            StExec: begin
               stage_en = 1'b1;
               cnt_en   = 1'b1;
               if (cnt_zero) begin
                  state_d = StWrite;
               end
            end
            StWrite: begin
               ld_res  = 1'b1;
               state_d = StDone;
            end
            StDone: begin
               out_valid = 1'b1;
               if (out_ready) begin
                  done_cnt_d = done_cnt_q + 1'b1;
                  state_d    = StGetA;
               end
            end
            default: begin
               state_d = StGetA;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StGetA;
         done_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         done_cnt_q <= done_cnt_d;
      end
   end

   assign done_cnt = done_cnt_q;

`ifdef FP_ADD_CTRL_SPECIAL_EN
   logic a_special_q;
   logic special_q;

   assign special_hit = a_special_q | is_special(in_data);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_special_q <= 1'b0;
         special_q   <= 1'b0;
      end else begin
         if (ld_a) begin
            a_special_q <= is_special(in_data);
         end
         if (ld_b) begin
            special_q <= special_hit;
         end
      end
   end

   assign sel_special = ld_res & special_q;
`else
   logic unused_in_data;

   assign special_hit    = 1'b0;
   assign sel_special    = 1'b0;
   assign unused_in_data = ^in_data;
`endif

endmodule

// File: tb/tb_fp_add_ctrl.sv
// Cycle-exact bench for fp_add_ctrl; honours FP_ADD_CTRL_SPECIAL_EN when defined.
module tb_fp_add_ctrl;

   localparam int unsigned LAT = 3;
   localparam int unsigned CW  = 4;
`ifdef FP_ADD_CTRL_SPECIAL_EN
   localparam bit SPEC_EN = 1'b1;
`else
   localparam bit SPEC_EN = 1'b0;
`endif

   // {in_ready, ld_a, ld_b, stage_en, ld_res, out_valid, busy}
   localparam logic [6:0] E_RST    = 7'b0000000;
   localparam logic [6:0] E_GA     = 7'b1000000;
   localparam logic [6:0] E_GA_ACC = 7'b1100000;
   localparam logic [6:0] E_GB     = 7'b1000001;
   localparam logic [6:0] E_GB_ACC = 7'b1010001;
   localparam logic [6:0] E_EX     = 7'b0001001;
   localparam logic [6:0] E_WR     = 7'b0000101;
   localparam logic [6:0] E_DN     = 7'b0000011;

   typedef struct {
      logic        rst;
      logic        iv;
      logic [31:0] d;
      logic        ordy;
      logic [6:0]  e;
      logic        sp;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [31:0]   in_data;
   logic          in_ready;
   logic          ld_a;
   logic          ld_b;
   logic          stage_en;
   logic          ld_res;
   logic          sel_special;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic [CW-1:0] done_cnt;

   int            total = 0;
   int            bad   = 0;
   vec_t          vecs[$];
   logic          sb[$];
   logic [CW-1:0] cnt_m;
   logic          exp_sp;

   fp_add_ctrl #(
      .ADD_LATENCY (LAT),
      .CNT_W       (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .ld_a        (ld_a),
      .ld_b        (ld_b),
      .stage_en    (stage_en),
      .ld_res      (ld_res),
      .sel_special (sel_special),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .busy        (busy),
      .done_cnt    (done_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   function automatic logic is_sp(input logic [31:0] d);
      return d[30:23] == 8'hFF;
   endfunction

   function automatic void add(input logic rst, input logic iv, input logic [31:0] d,
                               input logic ordy, input logic [6:0] e, input logic sp);
      vec_t v;
      v.rst  = rst;
      v.iv   = iv;
      v.d    = d;
      v.ordy = ordy;
      v.e    = e;
      v.sp   = sp;
      vecs.push_back(v);
   endfunction

   // One full operation; gap = idle cycles before B, hold = cycles out_ready stays low.
   function automatic void add_op(input logic [31:0] a, input logic [31:0] b,
                                  input int gap, input int hold);
      logic sp;
      sp = SPEC_EN && (is_sp(a) || is_sp(b));
      add(1'b1, 1'b1, a, 1'b1, E_GA_ACC, 1'b0);
      for (int i = 0; i < gap; i++) add(1'b1, 1'b0, 32'h0, 1'b1, E_GB, 1'b0);
      add(1'b1, 1'b1, b, 1'b1, E_GB_ACC, sp);
      if (!sp) begin
         for (int i = 0; i < int'(LAT); i++) add(1'b1, 1'b1, 32'h7F800000, 1'b1, E_EX, 1'b0);
      end
      add(1'b1, 1'b0, 32'h0, 1'b1, E_WR, 1'b0);
      for (int i = 0; i < hold; i++) add(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, E_DN, 1'b0);
      add(1'b1, 1'b0, 32'h0, 1'b1, E_DN, 1'b0);
   endfunction

   // Entered at posedge+1: drive, compare at negedge, advance to next posedge+1.
   task automatic step(input vec_t v, input int idx);
      reset     = v.rst;
      in_valid  = v.iv;
      in_data   = v.d;
      out_ready = v.ordy;
      if (!v.rst) begin
         cnt_m = '0;
         sb.delete();
      end
      @(negedge clk);
      chk($sformatf("ctl[%0d]", idx),
          32'({in_ready, ld_a, ld_b, stage_en, ld_res, out_valid, busy}), 32'(v.e));
      chk($sformatf("done_cnt[%0d]", idx), 32'(done_cnt), 32'(cnt_m));
      if (v.e[4]) sb.push_back(v.sp);
      if (v.e[1] && v.ordy) cnt_m = cnt_m + 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_vecs(input int base);
      for (int i = 0; i < vecs.size(); i++) step(vecs[i], base + i);
      vecs.delete();
   endtask

   // Scoreboard: each ld_res consumes the special flag expected for the oldest accepted B.
   always @(negedge clk) begin
      if (reset) begin
         if (ld_res) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL ld_res: pulse with nothing pending, got 1 required 0");
            end else begin
               exp_sp = sb.pop_front();
               chk("sel_special", 32'(sel_special), 32'(exp_sp));
            end
         end else begin
            chk("sel_special_idle", 32'(sel_special), 32'h0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      cnt_m     = '0;
      @(posedge clk);
      #1;

      // Reset with in_valid high, then basic op, stalled B, stalled consumer.
      add(1'b0, 1'b1, 32'h3F800000, 1'b1, E_RST, 1'b0);
      add(1'b0, 1'b1, 32'h3F800000, 1'b1, E_RST, 1'b0);
      add_op(32'h3F800000, 32'h40000000, 0, 0);
      add(1'b1, 1'b0, 32'h0, 1'b1, E_GA, 1'b0);
      add_op(32'h40400000, 32'h40800000, 5, 0);
      add(1'b1, 1'b0, 32'h0, 1'b1, E_GA, 1'b0);
      add_op(32'hC0000000, 32'h3F000000, 0, 10);
      add(1'b1, 1'b0, 32'h0, 1'b1, E_GA, 1'b0);
      run_vecs(0);

      // Asynchronous reset in the middle of EXEC.
      add(1'b1, 1'b1, 32'h41200000, 1'b1, E_GA_ACC, 1'b0);
      add(1'b1, 1'b1, 32'h41300000, 1'b1, E_GB_ACC, 1'b0);
      add(1'b1, 1'b0, 32'h0, 1'b1, E_EX, 1'b0);
      run_vecs(100);
      in_valid = 1'b1;
      reset    = 1'b0;
      #1;
      chk("async_rst_out",
          32'({in_ready, ld_a, ld_b, stage_en, ld_res, out_valid, busy, sel_special}), 32'h0);
      chk("async_rst_cnt", 32'(done_cnt), 32'h0);
      cnt_m = '0;
      sb.delete();
      @(posedge clk);
      #1;
      v.rst  = 1'b1;
      v.iv   = 1'b0;
      v.d    = 32'h0;
      v.ordy = 1'b1;
      v.e    = E_GA;
      v.sp   = 1'b0;
      step(v, 200);

      // Sixteen back-to-back ops wrap the 4-bit counter; then Inf/NaN operands.
      for (int i = 0; i < 16; i++) begin
         add_op($urandom & 32'hBFFFFFFF, $urandom & 32'hBFFFFFFF, 0, 0);
      end
      add(1'b1, 1'b0, 32'h0, 1'b1, E_GA, 1'b0);
      add_op(32'h7F800000, 32'h3F800000, 0, 0);
      add(1'b1, 1'b0, 32'h0, 1'b1, E_GA, 1'b0);
      add_op(32'h3F800000, 32'hFFC00000, 0, 2);
      add_op(32'h3F800000, 32'h40000000, 0, 0);
      add(1'b1, 1'b0, 32'h0, 1'b1, E_GA, 1'b0);
      run_vecs(300);

      chk("sb_drained", 32'(sb.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_add_ctrl.md
# fp_add_ctrl

Sequencing controller for the single-precision floating-point adder. It accepts operands A then B over one 32-bit valid/ready bus and drives the write enables of the operand PIPO registers. It steps the adder pipeline for a fixed latency, loads the result register, then holds the result valid until the consumer accepts it. It sits between the operand source and the adder datapath and owns all of its enables.

## Interface
- ADD_LATENCY, 3, cycles of stage_en the adder pipeline needs (legal 1..15)
- CNT_W, 16, width of completed-operation counter
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  one clock; reset is asynchronous and active-low
- in_valid  in  1  operand beat present on in_data
- in_data  in  32  IEEE-754 single operand (first beat A, second beat B)
- in_ready  out  1  controller accepts an operand beat this cycle
- ld_a  out  1  write_enable for operand-A register
- ld_b  out  1  write_enable for operand-B register
- stage_en  out  1  advance adder pipeline one stage
- ld_res  out  1  write_enable for result register
- sel_special  out  1  result mux selects special-value path (valid with ld_res)
- out_valid  out  1  result register holds a valid sum
- out_ready  in  1  consumer accepts result
- busy  out  1  operation in progress (state not GET_A)
- done_cnt  out  CNT_W  count of results handed off

## Operation
- States: GET_A, GET_B, EXEC, WRITE, DONE.
- GET_A: in_ready=1; on in_valid, ld_a=1 (same cycle, Mealy) -> GET_B.
- GET_B: in_ready=1; on in_valid, ld_b=1; -> EXEC, down-counter loaded with ADD_LATENCY-1.
- EXEC: stage_en=1 every cycle; counter decrements; at counter==0 -> WRITE.
- WRITE: ld_res=1 for exactly one cycle -> DONE.
- DONE: out_valid=1; on out_ready, done_cnt increments modulo 2^CNT_W (wraps to 0 at all-ones) -> GET_A.
- in_ready is 0 in EXEC, WRITE, DONE; in_valid there is ignored and the beat is not consumed.
- ld_a, ld_b, stage_en, ld_res never asserted together; each is 0 outside its state.
- in_valid held low in GET_B: controller waits indefinitely; A register holds its value.
- out_ready held low: DONE persists and out_valid remains 1; ld_res is not re-pulsed.

## Timing
- Reset (reset=0): state GET_A, counter 0, done_cnt 0. All outputs are 0 while reset is low, including in_ready. in_ready=1 from the first cycle after release.
- Reset mid-operation aborts immediately with no ld_res pulse and no done_cnt increment.
- B accepted at edge k: stage_en high for cycles k+1..k+ADD_LATENCY. ld_res is high in cycle k+ADD_LATENCY+1. out_valid rises in cycle k+ADD_LATENCY+2.
- Minimum operation period: 2 + ADD_LATENCY + 1 + 1 cycles with in_valid and out_ready held high.
- The next A can be accepted in the cycle after the out_valid/out_ready handshake, never in the same cycle.

## Configuration
- FP_ADD_CTRL_SPECIAL_EN defined:
  - At A capture, a flag records whether in_data[30:23]==8'hFF.
  - At B capture, if either the flag or in_data[30:23]==8'hFF is set, the controller skips EXEC and goes GET_B -> WRITE, with sel_special=1 during that WRITE cycle.
  - Result is valid in cycle k+2.
  - The flag is cleared on reset and at A capture.
- FP_ADD_CTRL_SPECIAL_EN not defined:
  - sel_special is tied 0.
  - No flag logic is built.
  - Every operation passes through EXEC.

## Structure
- Package fp_add_pkg holds:
  - state enum (GET_A, GET_B, EXEC, WRITE, DONE)
  - field constants EXP_MSB=30, EXP_LSB=23, EXP_ALL_ONES=8'hFF
  - latency counter width of 4 bits
- One sub-module, fp_add_lat_cnt: loadable 4-bit down-counter with load, enable and zero flag. The FSM stays in fp_add_ctrl.

## Test plan
- Reset release, A=32'h3F800000 then B=32'h40000000 back-to-back, out_ready=1, ADD_LATENCY=3:
  - ld_a cycle 0, ld_b cycle 1, stage_en cycles 2-4, ld_res cycle 5, out_valid cycle 6.
  - done_cnt becomes 1.
- in_valid dropped for 5 cycles after A: state stays GET_B with in_ready=1 and no stage_en. ld_b fires on the first in_valid cycle after that.
- out_ready low 10 cycles in DONE: out_valid stays 1 and ld_res pulses once only. in_ready=0 throughout, and in_valid asserted during that time is not consumed.
- reset pulled low during EXEC: all outputs are 0 immediately and done_cnt is 0. After release, state is GET_A with in_ready=1.
- CNT_W=4: run 16 operations; done_cnt counts up to 15, then wraps to 0.
- With FP_ADD_CTRL_SPECIAL_EN, A=32'h7F800000, B=32'h3F800000: no stage_en; ld_res and sel_special are high in cycle 2. Without the macro, the same stimulus gives 3 stage_en cycles and sel_special stays 0.
